// File: rtl/seg7_pkg.sv
// Shared types and constants for the countdown 7-segment display stage.
// Segment patterns are active-low, ordered a..g with index 0 = a.
package seg7_pkg;

   localparam logic [0:6] SEG_0     = 7'b0000001;
   localparam logic [0:6] SEG_1     = 7'b1001111;
   localparam logic [0:6] SEG_2     = 7'b0010010;
   localparam logic [0:6] SEG_3     = 7'b0000110;
   localparam logic [0:6] SEG_4     = 7'b1001100;
   localparam logic [0:6] SEG_5     = 7'b0100100;
   localparam logic [0:6] SEG_6     = 7'b0100000;
   localparam logic [0:6] SEG_7     = 7'b0001111;
   localparam logic [0:6] SEG_8     = 7'b0000000;
   localparam logic [0:6] SEG_9     = 7'b0000100;
   localparam logic [0:6] SEG_BLANK = 7'b1111111;
   localparam logic [0:6] SEG_DASH  = 7'b1111110;

   typedef logic [3:0] digit_t;
   localparam digit_t DIG_BLANK = 4'd10;
   localparam digit_t DIG_DASH  = 4'd11;

   typedef enum logic [1:0] {IDLE, CONV1, CONV2, COMMIT} state_t;

endpackage

// File: rtl/seg7_decode.sv
// Digit code to active-low segment pattern; purely combinational, zero latency.
// No flow control; codes above DASH decode to blank.
module seg7_decode
   import seg7_pkg::*;
(
   input  digit_t     code_i,
   output logic [0:6] seg_o
);

   always_comb begin
      seg_o = SEG_BLANK;
      case (code_i)
         4'd0:     seg_o = SEG_0;
         4'd1:     seg_o = SEG_1;
         4'd2:     seg_o = SEG_2;
         4'd3:     seg_o = SEG_3;
         4'd4:     seg_o = SEG_4;
         4'd5:     seg_o = SEG_5;
         4'd6:     seg_o = SEG_6;
         4'd7:     seg_o = SEG_7;
         4'd8:     seg_o = SEG_8;
         4'd9:     seg_o = SEG_9;
         DIG_DASH: seg_o = SEG_DASH;
         default:  seg_o = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/seg7_countdown_scan.sv
// Two countdown values -> BCD by repeated subtraction -> 4-digit multiplexed display.
// upd to done is (tens1+1)+(tens2+1)+1 cycles; upd is dropped while busy or in COMMIT.
module seg7_countdown_scan
   import seg7_pkg::*;
#(
   parameter int REFRESH_DIV = 50000,
   parameter bit BLANK_LZ    = 1'b1,
   parameter int CNT_W       = 7
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             upd,
   input  logic [CNT_W-1:0] t1,
   input  logic [CNT_W-1:0] t2,
   output logic             busy,
   output logic             done,
   output logic [0:6]       a_to_g,
   output logic [3:0]       an,
   output logic             dp
);

   localparam int               PW        = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [PW-1:0]    PRESC_MAX = PW'(REFRESH_DIV - 1);
   localparam logic [CNT_W-1:0] TEN       = CNT_W'(10);
   localparam logic [CNT_W-1:0] MAX_VAL   = CNT_W'(99);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] rem_q, rem_d, t2_q, t2_d;
   digit_t           tens_q, tens_d;
   logic             oor1_q, oor1_d, oor2_q, oor2_d;
   digit_t [3:0]     conv_q, conv_d, disp_q, disp_d;

   logic [PW-1:0]    presc_q, presc_d;
   logic [1:0]       idx_q, idx_d;
   logic             started_q, started_d;
   logic             wrap;
   digit_t           sel_code;
   logic [0:6]       seg_dec, seg_d, seg_q;
   logic [3:0]       an_d, an_q;
   logic             dp_d, dp_q;

   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      t2_d    = t2_q;
      tens_d  = tens_q;
      oor1_d  = oor1_q;
      oor2_d  = oor2_q;
      conv_d  = conv_q;
      disp_d  = disp_q;
      busy    = 1'b0;
      done    = 1'b0;
      case (state_q)
         IDLE: begin
            if (upd) begin
               rem_d   = t1;
               t2_d    = t2;
               tens_d  = '0;
               oor1_d  = (t1 > MAX_VAL);
               oor2_d  = (t2 > MAX_VAL);
               state_d = CONV1;
            end
         end
         CONV1: begin
            busy = 1'b1;
            if (!oor1_q && rem_q >= TEN) begin
               rem_d  = rem_q - TEN;
               tens_d = tens_q + 4'd1;
            end else begin
               conv_d[3] = oor1_q ? DIG_DASH : tens_q;
               conv_d[2] = oor1_q ? DIG_DASH : digit_t'(rem_q[3:0]);
               rem_d     = t2_q;
               tens_d    = '0;
               state_d   = CONV2;
            end
         end
         CONV2: begin
            busy = 1'b1;
            if (!oor2_q && rem_q >= TEN) begin
               rem_d  = rem_q - TEN;
               tens_d = tens_q + 4'd1;
            end else begin
               conv_d[1] = oor2_q ? DIG_DASH : tens_q;
               conv_d[0] = oor2_q ? DIG_DASH : digit_t'(rem_q[3:0]);
               state_d   = COMMIT;
            end
         end
         COMMIT: begin
            done    = 1'b1;
            disp_d  = conv_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs are computed from the next index so they switch on the same edge as idx_q.
   always_comb begin
      wrap      = (presc_q == PRESC_MAX);
      presc_d   = wrap ? '0 : presc_q + PW'(1);
      idx_d     = wrap ? idx_q + 2'd1 : idx_q;
      started_d = started_q | wrap;
      sel_code  = disp_q[idx_d];
      if (BLANK_LZ && idx_d[0] && sel_code == 4'd0) begin
         sel_code = DIG_BLANK;
      end
      an_d  = 4'b1111;
      seg_d = SEG_BLANK;
      dp_d  = 1'b1;
      if (started_d) begin
         an_d  = ~(4'b0001 << idx_d);
         seg_d = seg_dec;
         dp_d  = (idx_d != 2'd2);
      end
   end

   seg7_decode u_decode (
      .code_i (sel_code),
      .seg_o  (seg_dec)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         rem_q     <= '0;
         t2_q      <= '0;
         tens_q    <= '0;
         oor1_q    <= 1'b0;
         oor2_q    <= 1'b0;
         conv_q    <= '0;
         disp_q    <= '0;
         presc_q   <= '0;
         idx_q     <= '0;
         started_q <= 1'b0;
         an_q      <= 4'b1111;
         seg_q     <= SEG_BLANK;
         dp_q      <= 1'b1;
      end else begin
         state_q   <= state_d;
         rem_q     <= rem_d;
         t2_q      <= t2_d;
         tens_q    <= tens_d;
         oor1_q    <= oor1_d;
         oor2_q    <= oor2_d;
         conv_q    <= conv_d;
         disp_q    <= disp_d;
         presc_q   <= presc_d;
         idx_q     <= idx_d;
         started_q <= started_d;
         an_q      <= an_d;
         seg_q     <= seg_d;
         dp_q      <= dp_d;
      end
   end

   assign an     = an_q;
   assign a_to_g = seg_q;
   assign dp     = dp_q;

endmodule

// File: tb/tb_seg7_countdown_scan.sv
// Directed bench for seg7_countdown_scan with REFRESH_DIV=4 and leading-zero blanking.
module tb_seg7_countdown_scan;

   localparam logic [6:0] S0 = 7'b0000001;
   localparam logic [6:0] S2 = 7'b0010010;
   localparam logic [6:0] S3 = 7'b0000110;
   localparam logic [6:0] S4 = 7'b1001100;
   localparam logic [6:0] S5 = 7'b0100100;
   localparam logic [6:0] S7 = 7'b0001111;
   localparam logic [6:0] S8 = 7'b0000000;
   localparam logic [6:0] S9 = 7'b0000100;
   localparam logic [6:0] SB = 7'b1111111;
   localparam logic [6:0] SD = 7'b1111110;

   logic       clk = 1'b0;
   logic       reset;
   logic       upd;
   logic [6:0] t1, t2;
   logic       busy, done;
   logic [0:6] a_to_g;
   logic [3:0] an;
   logic       dp;

   int n_vec = 0;
   int n_err = 0;

   seg7_countdown_scan #(.REFRESH_DIV(4), .BLANK_LZ(1'b1), .CNT_W(7)) dut (
      .clk    (clk),
      .reset  (reset),
      .upd    (upd),
      .t1     (t1),
      .t2     (t2),
      .busy   (busy),
      .done   (done),
      .a_to_g (a_to_g),
      .an     (an),
      .dp     (dp)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Wait for digit idx to be selected, then compare its segments and dp.
   task automatic show(input string tag, input int idx, input logic [6:0] seg, input logic exp_dp);
      logic [3:0] one;
      logic [3:0] want;
      bit         hit;
      one  = 4'b0001;
      want = ~(one << idx);
      hit  = 1'b0;
      for (int k = 0; k < 20; k++) begin
         if (an === want) begin
            hit = 1'b1;
            break;
         end
         @(negedge clk);
      end
      chk({tag, "_sel"}, 32'(hit), 32'd1);
      chk({tag, "_seg"}, 32'(a_to_g), 32'(seg));
      chk({tag, "_dp"}, 32'(dp), 32'(exp_dp));
   endtask

   task automatic run_upd(input int a, input int b, input int inj, output int lat);
      lat = -1;
      @(negedge clk);
      upd = 1'b1;
      t1  = 7'(a);
      t2  = 7'(b);
      for (int n = 1; n <= 40; n++) begin
         @(negedge clk);
         if (n == 1) begin
            upd = 1'b0;
            chk("busy_after_upd", 32'(busy), 32'd1);
         end
         if (n == inj) begin
            upd = 1'b1;
            t1  = 7'd11;
            t2  = 7'd22;
         end else if (n == inj + 1) begin
            upd = 1'b0;
         end
         if (done) begin
            lat = n;
            break;
         end
      end
      @(negedge clk);
      chk("done_one_cycle", 32'(done), 32'd0);
      chk("idle_not_busy", 32'(busy), 32'd0);
      @(negedge clk);
   endtask

   task automatic show_all(input string tag, input logic [6:0] d3, input logic [6:0] d2,
                           input logic [6:0] d1, input logic [6:0] d0);
      show({tag, "_i3"}, 3, d3, 1'b1);
      show({tag, "_i2"}, 2, d2, 1'b0);
      show({tag, "_i1"}, 1, d1, 1'b1);
      show({tag, "_i0"}, 0, d0, 1'b1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int         lat;
      int         dcnt;
      bit         hit;
      logic [3:0] one;
      logic [3:0] want;

      reset = 1'b1;
      upd   = 1'b0;
      t1    = '0;
      t2    = '0;
      #3;
      chk("rst_an", 32'(an), 32'hF);
      chk("rst_seg", 32'(a_to_g), 32'h7F);
      chk("rst_dp", 32'(dp), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      @(negedge clk);
      reset = 1'b0;

      // Scan order: first wrap selects index 1, then 4 cycles per digit.
      hit = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (an !== 4'hF) begin
            hit = 1'b1;
            break;
         end
      end
      chk("first_wrap_seen", 32'(hit), 32'd1);
      chk("first_an", 32'(an), 32'b1101);
      one = 4'b0001;
      for (int i = 0; i < 32; i++) begin
         want = ~(one << ((1 + i / 4) % 4));
         chk("scan_an", 32'(an), 32'(want));
         @(negedge clk);
      end

      // Asynchronous reset in the middle of a digit slot.
      @(negedge clk);
      @(posedge clk);
      #1 reset = 1'b1;
      #1;
      chk("async_an", 32'(an), 32'hF);
      chk("async_seg", 32'(a_to_g), 32'h7F);
      chk("async_dp", 32'(dp), 32'd1);
      chk("async_busy", 32'(busy), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      show_all("zero", SB, S0, SB, S0);

      run_upd(37, 5, -10, lat);
      chk("lat_37_5", 32'(lat), 32'd6);
      show_all("v37_5", S3, S7, SB, S5);

      run_upd(99, 99, 5, lat);
      chk("lat_99_99", 32'(lat), 32'd21);
      show_all("v99_99", S9, S9, S9, S9);
      dcnt = 0;
      for (int k = 0; k < 25; k++) begin
         @(negedge clk);
         if (done) dcnt++;
      end
      chk("ignored_upd_no_done", 32'(dcnt), 32'd0);

      run_upd(120, 0, -10, lat);
      chk("lat_120_0", 32'(lat), 32'd3);
      show_all("v120_0", SD, SD, SB, S0);

      // Reset while converting direction 2 of 42/88.
      @(negedge clk);
      upd = 1'b1;
      t1  = 7'd42;
      t2  = 7'd88;
      dcnt = 0;
      for (int n = 1; n <= 8; n++) begin
         @(negedge clk);
         if (n == 1) upd = 1'b0;
         if (done) dcnt++;
      end
      reset = 1'b1;
      #1;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_an", 32'(an), 32'hF);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         if (done) dcnt++;
      end
      chk("abort_no_done", 32'(dcnt), 32'd0);
      show_all("abort_zero", SB, S0, SB, S0);

      run_upd(42, 88, -10, lat);
      chk("lat_42_88", 32'(lat), 32'd15);
      show_all("v42_88", S4, S2, S8, S8);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/seg7_countdown_scan.md
Name: seg7_countdown_scan

Overview:
Downstream display stage for the two-direction traffic_light controller. It accepts the two remaining-time values (direction 1 and direction 2, binary 0..99) and converts them to BCD with a small sequential converter. It then time-multiplexes them onto the board's 4-digit common-anode 7-segment display through a_to_g/an/dp. Digits 3..2 show direction 1; digits 1..0 show direction 2.

Parameters:
REFRESH_DIV, 50000, clk cycles per digit slot (use 4 in simulation); must be >= 2
BLANK_LZ, 1, 1 = blank a tens digit equal to 0; 0 = show it
CNT_W, 7, width of binary countdown inputs

Ports:
clk  input  1  system clock (mclk domain)
reset  input  1  asynchronous, active-high reset
upd  input  1  single-cycle strobe; new values are present on t1/t2
t1  input  CNT_W  direction-1 remaining time, binary
t2  input  CNT_W  direction-2 remaining time, binary
busy  output  1  conversion in progress; upd is ignored while high
done  output  1  one-cycle pulse when new digits commit to display
a_to_g  output  [0:6]  segments a..g, index 0 = a, active-low
an  output  [3:0]  digit enables, one-hot active-low, an[3] = leftmost
dp  output  1  decimal point, active-low

Behaviour:
- Reset (async assert, sync release): an=4'b1111, a_to_g=7'b1111111, dp=1, busy=0, done=0, FSM=IDLE, scan counter=0, digit index=0, all display digit registers=0.
- Scan: a prescaler counts 0..REFRESH_DIV-1. At wrap, the digit index advances 0→1→2→3→0. an, a_to_g and dp are registered and update in the same cycle the index changes, so there is exactly one an bit low at any time after the first wrap. an stays 4'b1111 until the first wrap.
- Digit map: idx3 = t1 tens, idx2 = t1 ones, idx1 = t2 tens, idx0 = t2 ones. dp=0 only while idx2 is selected, as the separator between the two directions.
- Encoding: digits 0-9 use the standard active-low patterns (0 = 7'b0000001, 1 = 7'b1001111, 8 = 7'b0000000).
  - Code BLANK = 7'b1111111.
  - Code DASH = 7'b1111110 (g segment only).
- FSM states and transitions:
  - IDLE: upd=1 latches t1/t2 and goes to CONV1 with busy=1.
  - CONV1: each cycle, if rem>=10 then rem-=10 and tens++; otherwise store tens/ones for direction 1, load t2 and go to CONV2.
  - CONV2: same algorithm for direction 2, then go to COMMIT.
  - COMMIT: copy all four digits to the display registers atomically, pulse done=1, busy=0, return to IDLE.
- Latency from the upd cycle to the done cycle is (tens1+1) + (tens2+1) + 1 cycles, maximum 21. The display changes no earlier than the done cycle, and never shows a mix of old and new digits.
- Range: an input >99 marks that direction as "out of range" at latch time, skips its subtraction loop (1 cycle) and displays DASH DASH.
- upd during busy is ignored; there is no queue. upd in the same cycle as COMMIT is also ignored.
- BLANK_LZ=1: a tens digit of 0 shows BLANK. The ones digit is always shown, so a value of 0 displays " 0".
- Reset mid-conversion aborts it; the display returns to the reset state and the digits read 0 after reset.
- The scan runs independently of the FSM. Conversion never stalls the refresh.

Decomposition:
- Shared package seg7_pkg holds:
  - The active-low segment constants SEG_0..SEG_9, SEG_BLANK and SEG_DASH.
  - The digit-code type (4-bit, with codes 10 = BLANK and 11 = DASH).
  - The FSM state encoding.
- One natural sub-module: seg7_decode, which is purely combinational and maps a 4-bit digit code to a_to_g. The top keeps the FSM, the converter and the scan logic.

Test Plan:
- Reset asserted mid-scan, REFRESH_DIV=4 → an=1111, a_to_g=1111111, dp=1 immediately (async); busy=0.
- upd with t1=37, t2=5, BLANK_LZ=1 → done exactly 4+1+1=6 cycles after upd. The scan then shows idx3=SEG_3, idx2=SEG_7 with dp=0, idx1=BLANK, idx0=SEG_5.
- upd with t1=99, t2=99 → done after 10+10+1=21 cycles. A second upd issued 5 cycles in is ignored, and the display shows 99 99.
- upd with t1=120, t2=0 → done after 1+1+1=3 cycles. Display shows DASH DASH on idx3/idx2, BLANK on idx1 and SEG_0 on idx0.
- Scan check, REFRESH_DIV=4, over 32 cycles → each an bit is low for exactly 4 consecutive cycles in the order an[0],an[1],an[2],an[3]. an is never all-ones and never has two bits low after the first wrap.
- Reset during CONV2 of t1=42, t2=88 → done never pulses. After release all digits read 0 (idx0 = SEG_0, the tens digits blanked), and a new upd converts normally.
